// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Optional hit/miss counters are enabled with the DCACHE_STATS_EN macro.
module dcache_ctrl #(
  parameter int NUM_LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dc_req,
  input  logic [57:0] dc_line_addr,
  input  logic [2:0]  dc_word_select,
  input  logic [2:0]  dc_byte_offset,
  input  logic [63:0] dc_data_to_cache,
  input  logic        dc_read_write_n,
  input  logic [1:0]  store_type,
  output logic        dc_ack,
  output logic [63:0] dc_data_from_cache,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX  = $clog2(NUM_LINES);
  localparam int TAGW = 58 - IDX;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP} state_t;

  state_t state, state_next;

  logic [57:0] line_addr;
  logic [2:0]  word_sel;
  logic [2:0]  byte_off;
  logic [63:0] store_data;
  logic        is_load;
  logic [1:0]  stype;
  logic [2:0]  beat;
  logic [63:0] load_word, load_word_next;

  logic [NUM_LINES-1:0] valid;
  logic [TAGW-1:0]      tag_mem  [NUM_LINES];
  logic [63:0]          data_mem [NUM_LINES*8];

  logic [IDX-1:0]  idx;
  logic [TAGW-1:0] tag;
  logic [IDX+2:0]  word_index;
  logic [IDX+2:0]  refill_index;
  logic            hit;
  logic [63:0]     cached_word;
  logic [7:0]      merge_strb;
  logic [63:0]     merge_data;
  logic [63:0]     merge_mask;
  logic            last_beat;

  logic        mem_req_next, mem_we_next;
  logic [63:0] mem_addr_next, mem_wdata_next;
  logic [7:0]  mem_wstrb_next;
  logic [63:0] dc_data_next;

  // Places store data at its big-endian byte lanes; low offset bits are aligned away.
  function automatic logic [71:0] merge_store(input logic [1:0] st, input logic [2:0] off,
                                              input logic [63:0] d);
    logic [5:0]  sh;
    logic [63:0] w;
    logic [7:0]  s;
    sh = 6'd0;
    w  = 64'd0;
    s  = 8'd0;
    case (st)
      2'b00: begin
        sh = {3'd7 - off, 3'b000};
        w  = {56'd0, d[7:0]} << sh;
        s  = 8'h01 << (3'd7 - off);
      end
      2'b01: begin
        sh = {3'd6 - {off[2:1], 1'b0}, 3'b000};
        w  = {48'd0, d[15:0]} << sh;
        s  = 8'h03 << (3'd6 - {off[2:1], 1'b0});
      end
      2'b10: begin
        sh = {3'd4 - {off[2], 2'b00}, 3'b000};
        w  = {32'd0, d[31:0]} << sh;
        s  = 8'h0F << (3'd4 - {off[2], 2'b00});
      end
      default: begin
        w = d;
        s = 8'hFF;
      end
    endcase
    return {s, w};
  endfunction

  function automatic logic [63:0] strb_to_mask(input logic [7:0] s);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{s[i]}};
    end
    return m;
  endfunction

  assign idx          = line_addr[IDX-1:0];
  assign tag          = line_addr[57:IDX];
  assign word_index   = {idx, word_sel};
  assign refill_index = {idx, beat};
  assign hit          = valid[idx] && (tag_mem[idx] == tag);
  assign cached_word  = data_mem[word_index];
  assign {merge_strb, merge_data} = merge_store(stype, byte_off, store_data);
  assign merge_mask   = strb_to_mask(merge_strb);
  assign last_beat    = mem_rvalid && (beat == 3'd7);

  // Next state, the word returned to the requester, and next registered outputs.
  always_comb begin
    state_next     = state;
    load_word_next = load_word;
    case (state)
      IDLE: begin
        if (dc_req) state_next = LOOKUP;
        else        state_next = IDLE;
      end
      LOOKUP: begin
        if (is_load) begin
          load_word_next = cached_word;
          if (hit) state_next = RESP;
          else     state_next = REFILL;
        end else begin
          state_next = WRITE;
        end
      end
      REFILL: begin
        if (mem_rvalid && (beat == word_sel)) load_word_next = mem_rdata;
        else                                  load_word_next = load_word;
        if (last_beat) state_next = RESP;
        else           state_next = REFILL;
      end
      WRITE: begin
        if (mem_ack) state_next = RESP;
        else         state_next = WRITE;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    mem_req_next   = (state_next == REFILL) || (state_next == WRITE);
    mem_we_next    = (state_next == WRITE);
    mem_addr_next  = 64'd0;
    mem_wdata_next = 64'd0;
    mem_wstrb_next = 8'd0;
    if (state_next == REFILL) begin
      mem_addr_next = {line_addr, 6'b000000};
    end else if (state_next == WRITE) begin
      mem_addr_next  = {line_addr, word_sel, 3'b000};
      mem_wdata_next = merge_data;
      mem_wstrb_next = merge_strb;
    end else begin
      mem_addr_next = 64'd0;
    end
    if ((state_next == RESP) && is_load) dc_data_next = load_word_next;
    else                                 dc_data_next = 64'd0;
  end

  // State, request capture, beat counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      line_addr          <= 58'd0;
      word_sel           <= 3'd0;
      byte_off           <= 3'd0;
      store_data         <= 64'd0;
      is_load            <= 1'b0;
      stype              <= 2'd0;
      beat               <= 3'd0;
      load_word          <= 64'd0;
      dc_ack             <= 1'b0;
      dc_data_from_cache <= 64'd0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= 64'd0;
      mem_wdata          <= 64'd0;
      mem_wstrb          <= 8'd0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && dc_req) begin
        line_addr  <= dc_line_addr;
        word_sel   <= dc_word_select;
        byte_off   <= dc_byte_offset;
        store_data <= dc_data_to_cache;
        is_load    <= dc_read_write_n;
        stype      <= store_type;
      end
      if ((state == REFILL) && mem_rvalid) beat <= beat + 3'd1;
      else if (state != REFILL)            beat <= 3'd0;
      load_word          <= load_word_next;
      dc_ack             <= (state_next == RESP);
      dc_data_from_cache <= dc_data_next;
      mem_req            <= mem_req_next;
      mem_we             <= mem_we_next;
      mem_addr           <= mem_addr_next;
      mem_wdata          <= mem_wdata_next;
      mem_wstrb          <= mem_wstrb_next;
    end
  end

  // Valid bits: a line is invalid while it is being refilled, valid after beat 7.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if ((state == LOOKUP) && is_load && !hit) begin
      valid[idx] <= 1'b0;
    end else if ((state == REFILL) && last_beat) begin
      valid[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; validity is governed by the valid bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((state == REFILL) && mem_rvalid) begin
        data_mem[refill_index] <= mem_rdata;
        if (beat == 3'd7) tag_mem[idx] <= tag;
      end else if ((state == LOOKUP) && !is_load && hit) begin
        data_mem[word_index] <= (cached_word & ~merge_mask) | (merge_data & merge_mask);
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // Each load lookup counts as exactly one hit or one miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if ((state == LOOKUP) && is_load) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
